// File: rtl/cam_wr_pkg.sv
// Shared types and constants for the camera frame RAM writer.
// FIFO entries hold {word address, byteenable, data}.
package cam_wr_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

  localparam logic [3:0]  BE_FULL       = 4'hF;
  localparam logic [3:0]  BE_LOW        = 4'h3;
  localparam int unsigned ENTRY_EXTRA_W = 36;

  function automatic int unsigned entry_w(input int unsigned addr_w);
    return addr_w + ENTRY_EXTRA_W;
  endfunction

endpackage

// File: rtl/cam_wr_fifo.sv
// Synchronous FIFO with registered full/empty; a push while full is accepted only if a pop happens in the same cycle.
// Read data is the combinational head entry, valid whenever empty_o is low.
module cam_wr_fifo #(
  parameter int unsigned W     = 52,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q, wr_en, rd_en;

  always_comb begin
    rd_en = pop_i && !empty_q;
    wr_en = push_i && (!full_q || rd_en);
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/camera_pixel_ram_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and writes one frame per arm to the frame RAM over Avalon-MM.
// Pixel to avm_write is 2 cycles; waitrequest stalls the output register and a full FIFO drops words. CAM_WR_STATS_EN adds counters.
module camera_pixel_ram_writer
  import cam_wr_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DEPTH_WORDS  = 40192,
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
`ifdef CAM_WR_STATS_EN
  ,
  output logic [ADDR_W-1:0] words_written,
  output logic [15:0]       words_dropped
`endif
);
  localparam int unsigned EW = entry_w(ADDR_W);

  state_t            state_q;
  logic [31:0]       pix_cnt_q, pix_cnt_d;
  logic [15:0]       lo_q;
  logic              have_lo_q;
  logic [ADDR_W-1:0] waddr_q, addr_q;
  logic [3:0]        be_q, push_be;
  logic [31:0]       data_q, push_dat;
  logic              wr_q, busy_q, done_q, ovf_q;
  logic              take_pix, trunc, last_pix, push_req, push, pop, drop, in_range;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty;

  always_comb begin
    take_pix  = pix_valid && ((state_q == ARMED && pix_sof) || (state_q == CAPTURE && !pix_sof));
    trunc     = pix_valid && pix_sof && (state_q == CAPTURE);
    pix_cnt_d = (state_q == ARMED) ? 32'd1 : pix_cnt_q + 32'd1;
    last_pix  = take_pix && (pix_cnt_d == FRAME_PIXELS);
    push_req  = 1'b0;
    push_dat  = '0;
    push_be   = BE_FULL;
    if (take_pix && have_lo_q) begin
      push_req = 1'b1;
      push_dat = {pix_data, lo_q};
    end else if (last_pix) begin
      push_req = 1'b1;
      push_dat = {16'h0000, pix_data};
      push_be  = BE_LOW;
    end else if (trunc && have_lo_q) begin
      push_req = 1'b1;
      push_dat = {16'h0000, lo_q};
      push_be  = BE_LOW;
    end
    in_range = 32'(waddr_q) < DEPTH_WORDS;
    pop      = !fifo_empty && (!wr_q || !avm_waitrequest);
    push     = push_req && in_range && (!fifo_full || pop);
    drop     = push_req && !push;
  end

  cam_wr_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({waddr_q, push_be, push_dat}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      lo_q      <= '0;
      have_lo_q <= 1'b0;
      waddr_q   <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (take_pix) begin
        pix_cnt_q <= pix_cnt_d;
        have_lo_q <= !have_lo_q;
        if (!have_lo_q) lo_q <= pix_data;
      end
      // Address advances for dropped words too, keeping later words at their true positions.
      if (push_req) waddr_q <= waddr_q + ADDR_W'(1);
      if (drop) ovf_q <= 1'b1;

      if (pop) begin
        wr_q   <= 1'b1;
        addr_q <= fifo_rdata[EW-1 -: ADDR_W];
        be_q   <= fifo_rdata[35:32];
        data_q <= fifo_rdata[31:0];
      end else if (wr_q && !avm_waitrequest) begin
        wr_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (arm) begin
          state_q <= ARMED;
          busy_q  <= 1'b1;
          ovf_q   <= 1'b0;
          waddr_q <= '0;
        end
        ARMED: if (take_pix) begin
          state_q <= last_pix ? DRAIN : CAPTURE;
          if (last_pix) have_lo_q <= 1'b0;
        end
        CAPTURE: if (last_pix || trunc) begin
          state_q   <= DRAIN;
          have_lo_q <= 1'b0;
        end
        DRAIN: if (fifo_empty && !wr_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = data_q;
  assign avm_write      = wr_q;
  assign avm_chipselect = wr_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;

`ifdef CAM_WR_STATS_EN
  logic [ADDR_W-1:0] ww_q;
  logic [15:0]       wd_q;

  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE && arm)) begin
      ww_q <= '0;
      wd_q <= '0;
    end else begin
      if (wr_q && !avm_waitrequest) ww_q <= ww_q + ADDR_W'(1);
      if (drop && wd_q != 16'hFFFF) wd_q <= wd_q + 16'd1;
    end
  end

  assign words_written = ww_q;
  assign words_dropped = wd_q;
`endif

endmodule

// File: tb/tb_camera_pixel_ram_writer.sv
// Self-checking bench: four writer instances with different geometries share stimulus; one is observed at a time.
// Expected writes are queued when pixels are driven and compared as transfers complete.
module tb_camera_pixel_ram_writer;

  logic        clk, reset, arm, pix_valid, pix_sof, avm_waitrequest;
  logic [15:0] pix_data;
  logic [1:0]  sel;

  logic [15:0] o_addr [4];
  logic [3:0]  o_be   [4];
  logic [31:0] o_dat  [4];
  logic        o_cs [4], o_wr [4], o_busy [4], o_done [4], o_ovf [4];
`ifdef CAM_WR_STATS_EN
  logic [15:0] o_ww [4], o_wd [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    camera_pixel_ram_writer #(
      .ADDR_W       (16),
      .DEPTH_WORDS  (g == 3 ? 2 : 40192),
      .FRAME_PIXELS (g == 0 ? 4 : g == 1 ? 3 : g == 2 ? 40 : 6),
      .FIFO_DEPTH   (8)
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .arm             (arm),
      .pix_valid       (pix_valid),
      .pix_sof         (pix_sof),
      .pix_data        (pix_data),
      .avm_address     (o_addr[g]),
      .avm_byteenable  (o_be[g]),
      .avm_chipselect  (o_cs[g]),
      .avm_write       (o_wr[g]),
      .avm_writedata   (o_dat[g]),
      .avm_waitrequest (avm_waitrequest),
      .busy            (o_busy[g]),
      .frame_done      (o_done[g]),
      .overflow        (o_ovf[g])
`ifdef CAM_WR_STATS_EN
      ,
      .words_written   (o_ww[g]),
      .words_dropped   (o_wd[g])
`endif
    );
  end

  logic [15:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_chipselect, avm_write, busy, frame_done, overflow;
  assign avm_address    = o_addr[sel];
  assign avm_byteenable = o_be[sel];
  assign avm_writedata  = o_dat[sel];
  assign avm_chipselect = o_cs[sel];
  assign avm_write      = o_wr[sel];
  assign busy           = o_busy[sel];
  assign frame_done     = o_done[sel];
  assign overflow       = o_ovf[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q [$];
  int  checks = 0, errors = 0;
  int  wr_cnt = 0, done_cnt = 0;
  int  stall_left = 0;
  bit  hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waitrequest driver: either hold high, or stall the next presented word for stall_left cycles.
  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold) avm_waitrequest = 1'b1;
      else if (stall_left > 0 && avm_write) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else avm_waitrequest = 1'b0;
    end
  end

  // Write monitor on the falling edge: completes transfers against the queue and checks stall stability.
  initial begin
    bit          stall_prev;
    logic [15:0] pa;
    logic [3:0]  pb;
    logic [31:0] pd;
    wr_t         e;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) stall_prev = 0;
      else begin
        if (stall_prev) begin
          chk("hold_addr", avm_address, pa);
          chk("hold_be", avm_byteenable, pb);
          chk("hold_data", avm_writedata, pd);
          chk("hold_write", avm_write, 1);
        end
        if (avm_write && !avm_waitrequest) begin
          chk("chipselect", avm_chipselect, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", avm_address, avm_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", avm_address, e.a);
            chk("wr_data", avm_writedata, e.d);
            chk("wr_be", avm_byteenable, e.be);
          end
          wr_cnt++;
        end
        if (frame_done) done_cnt++;
        stall_prev = avm_write && avm_waitrequest;
        pa = avm_address;
        pb = avm_byteenable;
        pd = avm_writedata;
      end
    end
  end

  // Reference packer: pairs pixels, tracks the word address, keeps only words expected to reach the RAM.
  int          m_idx, m_keep, m_depth;
  bit          m_have;
  logic [15:0] m_lo;

  task automatic m_begin(input int keep, input int depth);
    m_idx = 0; m_keep = keep; m_depth = depth; m_have = 0;
  endtask

  task automatic m_word(input logic [31:0] d, input logic [3:0] be);
    if (m_idx < m_keep && m_idx < m_depth) exp_q.push_back('{a: 16'(m_idx), be: be, d: d});
    m_idx++;
  endtask

  task automatic m_pix(input logic [15:0] d);
    if (!m_have) begin
      m_lo = d; m_have = 1;
    end else begin
      m_word({d, m_lo}, 4'hF); m_have = 0;
    end
  endtask

  task automatic m_end();
    if (m_have) m_word({16'h0000, m_lo}, 4'h3);
    m_have = 0;
  endtask

  function automatic logic [15:0] pv(input int i);
    return 16'(i + 1) * 16'h1111;
  endfunction

  task automatic send_pix(input logic [15:0] d, input bit sof);
    pix_valid = 1'b1; pix_sof = sof; pix_data = d;
    @(posedge clk);
    #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    hold = 0; stall_left = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    wr_cnt = 0; done_cnt = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_frame_done_pulses"}, done_cnt, 1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_busy_end"}, busy, 0);
  endtask

  typedef struct {
    int inst, npix, stall, keep, depth, exp_words, exp_drop;
    bit exp_ovf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{inst: 0, npix: 4,  stall: 0,  keep: 999, depth: 40192, exp_words: 2,  exp_drop: 0,  exp_ovf: 0};
    vecs[1] = '{inst: 1, npix: 3,  stall: 0,  keep: 999, depth: 40192, exp_words: 2,  exp_drop: 0,  exp_ovf: 0};
    vecs[2] = '{inst: 2, npix: 40, stall: 5,  keep: 999, depth: 40192, exp_words: 20, exp_drop: 0,  exp_ovf: 0};
    vecs[3] = '{inst: 2, npix: 40, stall: -1, keep: 9,   depth: 40192, exp_words: 9,  exp_drop: 11, exp_ovf: 1};
    vecs[4] = '{inst: 3, npix: 6,  stall: 0,  keep: 999, depth: 2,     exp_words: 2,  exp_drop: 1,  exp_ovf: 1};

    sel = 0;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("rst%0d_write", s), avm_write, 0);
      chk($sformatf("rst%0d_cs", s), avm_chipselect, 0);
      chk($sformatf("rst%0d_addr", s), avm_address, 0);
      chk($sformatf("rst%0d_data", s), avm_writedata, 0);
      chk($sformatf("rst%0d_be", s), avm_byteenable, 0);
      chk($sformatf("rst%0d_busy", s), busy, 0);
      chk($sformatf("rst%0d_done", s), frame_done, 0);
      chk($sformatf("rst%0d_ovf", s), overflow, 0);
    end

    // Latency: word appears on avm_write two cycles after the odd pixel.
    do_reset();
    sel = 0;
    arm_pulse();
    m_begin(999, 40192);
    m_pix(pv(0)); send_pix(pv(0), 1);
    m_pix(pv(1)); send_pix(pv(1), 0);
    chk("lat_write_c1", avm_write, 0);
    @(posedge clk);
    #1;
    chk("lat_write_c2", avm_write, 1);
    m_pix(pv(2)); send_pix(pv(2), 0);
    m_pix(pv(3)); send_pix(pv(3), 0);
    wait_done("lat");

    for (int k = 0; k < 5; k++) begin
      vec_t v;
      string nm;
      v = vecs[k];
      nm = $sformatf("v%0d", k);
      do_reset();
      sel = 2'(v.inst);
      arm_pulse();
      chk({nm, "_busy"}, busy, 1);
      if (v.stall > 0) stall_left = v.stall;
      if (v.stall < 0) hold = 1;
      m_begin(v.keep, v.depth);
      for (int i = 0; i < v.npix; i++) begin
        m_pix(pv(i));
        send_pix(pv(i), i == 0);
      end
      m_end();
      hold = 0;
      wait_done(nm);
      chk({nm, "_words"}, wr_cnt, v.exp_words);
      chk({nm, "_ovf"}, overflow, v.exp_ovf);
`ifdef CAM_WR_STATS_EN
      chk({nm, "_words_written"}, o_ww[sel], v.exp_words);
      chk({nm, "_words_dropped"}, o_wd[sel], v.exp_drop);
`endif
    end

    // Sticky overflow from the last vector is cleared by the next arm.
    arm_pulse();
    chk("arm_clears_ovf", overflow, 0);
    chk("arm_sets_busy", busy, 1);
`ifdef CAM_WR_STATS_EN
    chk("arm_clears_dropped", o_wd[sel], 0);
`endif

    // Pixels before arm and non-sof pixels while armed are ignored; arm during capture is ignored.
    do_reset();
    sel = 0;
    for (int i = 0; i < 4; i++) send_pix(pv(i + 8), i == 0);
    arm_pulse();
    send_pix(16'hAAAA, 0);
    send_pix(16'hBBBB, 0);
    m_begin(999, 40192);
    m_pix(pv(0)); send_pix(pv(0), 1);
    m_pix(pv(1)); send_pix(pv(1), 0);
    arm_pulse();
    m_pix(pv(2)); send_pix(pv(2), 0);
    m_pix(pv(3)); send_pix(pv(3), 0);
    wait_done("ign");
    chk("ign_words", wr_cnt, 2);

    // A new sof after 5 pixels truncates the frame; the fifth pixel goes out as a partial word.
    do_reset();
    sel = 2;
    arm_pulse();
    m_begin(999, 40192);
    for (int i = 0; i < 5; i++) begin
      m_pix(pv(i));
      send_pix(pv(i), i == 0);
    end
    m_end();
    send_pix(16'h5A5A, 1);
    wait_done("trunc");
    chk("trunc_words", wr_cnt, 3);
    chk("trunc_ovf", overflow, 0);

    // Reset while a write is stalled and the FIFO has overflowed.
    do_reset();
    sel = 2;
    arm_pulse();
    hold = 1;
    for (int i = 0; i < 24; i++) send_pix(pv(i), i == 0);
    chk("pre_rst_write", avm_write, 1);
    chk("pre_rst_ovf", overflow, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_write", avm_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    reset = 1'b0;
    hold = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_words", wr_cnt, 0);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
